if_fetch_ctrl: RTL and testbench

- Instruction-fetch controller for the pipelined MIPS CPU. It owns the PC and drives the combinational instruction ROM.
- It loads the IF/ID pipeline register and applies the load-use stall (stall_n) and next-PC selection (pcsource) from ID.
- It adds a debug run/halt/single-step FSM that never splits a control-transfer instruction from its delay slot.
- It traps fetches outside the ROM window.

---
 rtl/if_pkg.sv | 26 ++
 rtl/if_cti_decode.sv | 20 ++
 rtl/if_fetch_ctrl.sv | 120 ++++++++++++
 tb/tb_if_fetch_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared encodings for the instruction-fetch stage: debug FSM states, next-PC
// select codes and the MIPS opcode/funct values used to recognise control transfers.
package if_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        STEP  = 2'd2,
        FAULT = 2'd3
    } dbg_state_t;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;
    localparam logic [1:0] PCSRC_J   = 2'b11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/if_cti_decode.sv
// Flags control-transfer instructions (j, jal, beq, bne, jr), i.e. anything
// followed by a delay slot that must not be separated from it.
module if_cti_decode
    import if_pkg::*;
(
    input  logic [31:0] i_inst,
    output logic        o_is_cti
);

    logic [5:0] w_opcode;
    logic [5:0] w_funct;

    assign w_opcode = i_inst[31:26];
    assign w_funct  = i_inst[5:0];

    assign o_is_cti = (w_opcode == OP_J)   || (w_opcode == OP_JAL) ||
                      (w_opcode == OP_BEQ) || (w_opcode == OP_BNE) ||
                      ((w_opcode == OP_RTYPE) && (w_funct == FUNCT_JR));

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF stage: owns the PC, loads IF/ID, and runs a debug run/halt/step FSM that
// keeps a control transfer and its delay slot together; out-of-window fetches trap.
module if_fetch_ctrl
    import if_pkg::*;
#(
    parameter int          IMEM_WORDS = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_n,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    input  logic        halt_req,
    input  logic        step_req,
    input  logic        resume_req,
    input  logic [31:0] imem_inst,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc4,
    output logic        id_valid,
    output logic [1:0]  dbg_state,
    output logic        fault
);

    localparam logic [31:0] FETCH_LIMIT = 32'(4 * IMEM_WORDS);

    dbg_state_t  r_state;
    dbg_state_t  w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_id_inst;
    logic [31:0] r_id_pc4;
    logic        r_id_valid;

    logic [31:0] w_pc4;
    logic [31:0] w_npc;
    logic        w_pc_bad;
    logic        w_is_cti;
    logic        w_fetch;

    if_cti_decode u_cti_decode (
        .i_inst   (imem_inst),
        .o_is_cti (w_is_cti)
    );

    assign w_pc4    = r_pc + 32'd4;
    // Also catches the 0xFFFF_FFFC -> 0 wrap, since such a PC is far outside the ROM.
    assign w_pc_bad = (r_pc[1:0] != 2'b00) || (r_pc >= FETCH_LIMIT);

    always_comb begin
        w_npc = w_pc4;
        case (pcsource)
            PCSRC_BR: w_npc = bpc;
            PCSRC_JR: w_npc = rpc;
            PCSRC_J:  w_npc = jpc;
            default:  w_npc = w_pc4;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_fetch      = 1'b0;
        case (r_state)
            RUN: begin
                if (w_pc_bad) begin
                    w_state_next = FAULT;
                end else begin
                    w_fetch = 1'b1;
                    // A CTI keeps us running so its delay slot is fetched next edge.
                    if (halt_req && !w_is_cti)
                        w_state_next = HALT;
                end
            end
            HALT: begin
                if (resume_req)
                    w_state_next = RUN;
                else if (step_req)
                    w_state_next = STEP;
            end
            STEP: begin
                if (w_pc_bad) begin
                    w_state_next = FAULT;
                end else begin
                    w_fetch = 1'b1;
                    if (!w_is_cti)
                        w_state_next = HALT;
                end
            end
            default: w_state_next = FAULT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RUN;
            r_pc       <= RESET_PC;
            r_id_inst  <= NOP;
            r_id_pc4   <= 32'h0;
            r_id_valid <= 1'b0;
        end else if (stall_n) begin
            r_state    <= w_state_next;
            r_pc       <= w_fetch ? w_npc : r_pc;
            r_id_inst  <= w_fetch ? imem_inst : NOP;
            r_id_pc4   <= w_pc4;
            r_id_valid <= w_fetch;
        end
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign id_inst   = r_id_inst;
    assign id_pc4    = r_id_pc4;
    assign id_valid  = r_id_valid;
    assign dbg_state = r_state;
    assign fault     = (r_state == FAULT);

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: a small program ROM plus hand-computed
// expectations for fetch, stall, delay-slot-safe halt, single step and faults.
module tb_if_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        stall_n;
    logic [1:0]  pcsource;
    logic [31:0] bpc;
    logic [31:0] rpc;
    logic [31:0] jpc;
    logic        halt_req;
    logic        step_req;
    logic        resume_req;
    logic [31:0] imem_inst;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] id_inst;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic [1:0]  dbg_state;
    logic        fault;

    logic [31:0] rom [0:63];
    int n_vec;
    int n_err;

    if_fetch_ctrl #(.IMEM_WORDS(64), .RESET_PC(32'h0)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_n    (stall_n),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .rpc        (rpc),
        .jpc        (jpc),
        .halt_req   (halt_req),
        .step_req   (step_req),
        .resume_req (resume_req),
        .imem_inst  (imem_inst),
        .imem_addr  (imem_addr),
        .pc         (pc),
        .id_inst    (id_inst),
        .id_pc4     (id_pc4),
        .id_valid   (id_valid),
        .dbg_state  (dbg_state),
        .fault      (fault)
    );

    assign imem_inst = rom[imem_addr[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        $display("edge t=%0t pc=%h id_inst=%h id_pc4=%h valid=%0b state=%0d fault=%0b",
                 $time, pc, id_inst, id_pc4, id_valid, dbg_state, fault);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic step_once();
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        tick();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 64; i++) rom[i] = 32'h0;
        rom[0]  = 32'h3c010000;
        rom[1]  = 32'h34240050;
        rom[2]  = 32'h0c00001b;  // jal 0x6C
        rom[3]  = 32'h20050004;
        rom[4]  = 32'hac820000;
        rom[5]  = 32'h8c890000;
        rom[6]  = 32'h03e00008;  // jr $31
        rom[27] = 32'h00004020;
        rom[28] = 32'h00a42820;
        rom[29] = 32'h20a5ffff;
        rom[30] = 32'h00852022;
        rom[31] = 32'h14a0fffc;  // bne
        rom[32] = 32'h20840004;

        rst = 1'b1; stall_n = 1'b1; pcsource = 2'b00;
        bpc = 32'h0; rpc = 32'h0; jpc = 32'h0;
        halt_req = 1'b0; step_req = 1'b0; resume_req = 1'b0;

        // Reset state, then straight-line fetch
        #12;
        check("rst_pc", pc, 32'h0);
        check("rst_inst", id_inst, 32'h0);
        check("rst_pc4", id_pc4, 32'h0);
        check("rst_valid", {31'b0, id_valid}, 32'h0);
        check("rst_state", {30'b0, dbg_state}, 32'h0);
        check("rst_fault", {31'b0, fault}, 32'h0);
        rst = 1'b0;
        tick(); check("f0_inst", id_inst, 32'h3c010000);
        tick(); check("f1_inst", id_inst, 32'h34240050);
        tick(); check("f2_inst", id_inst, 32'h0c00001b);
        check("f2_pc", pc, 32'h0000000C);
        check("f2_pc4", id_pc4, 32'h0000000C);
        check("f2_valid", {31'b0, id_valid}, 32'h1);
        tick(); tick();
        check("pre_stall_pc", pc, 32'h14);

        // Stall hold
        stall_n = 1'b0;
        tick(); tick();
        check("stall_pc", pc, 32'h14);
        check("stall_inst", id_inst, 32'hac820000);
        check("stall_valid", {31'b0, id_valid}, 32'h1);
        stall_n = 1'b1;
        tick();
        check("unstall_inst", id_inst, 32'h8c890000);
        check("unstall_pc", pc, 32'h18);
        check("unstall_pc4", id_pc4, 32'h18);

        // Halt requested on jal: delay slot must be fetched first
        do_reset();
        tick(); tick();
        halt_req = 1'b1;
        tick();
        check("jal_inst", id_inst, 32'h0c00001b);
        check("jal_state", {30'b0, dbg_state}, 32'h0);
        pcsource = 2'b11; jpc = 32'h6C;
        tick();
        check("ds_inst", id_inst, 32'h20050004);
        check("ds_pc", pc, 32'h6C);
        check("ds_state", {30'b0, dbg_state}, 32'h1);
        halt_req = 1'b0; pcsource = 2'b00;
        tick();
        check("halt_valid", {31'b0, id_valid}, 32'h0);
        check("halt_inst", id_inst, 32'h0);
        check("halt_pc4", id_pc4, 32'h70);
        tick();
        check("halt_pc", pc, 32'h6C);
        check("halt_state", {30'b0, dbg_state}, 32'h1);

        // Single step
        step_req = 1'b1;
        tick();
        check("step_state", {30'b0, dbg_state}, 32'h2);
        check("step_pc", pc, 32'h6C);
        step_req = 1'b0;
        tick();
        check("step_inst", id_inst, 32'h00004020);
        check("step_pc2", pc, 32'h70);
        check("step_back", {30'b0, dbg_state}, 32'h1);
        for (int i = 0; i < 3; i++) step_once();
        check("step3_pc", pc, 32'h7C);
        check("step3_inst", id_inst, 32'h00852022);

        // Step onto bne: two fetches, branch target honoured while stepping
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        tick();
        check("bne_inst", id_inst, 32'h14a0fffc);
        check("bne_state", {30'b0, dbg_state}, 32'h2);
        pcsource = 2'b01; bpc = 32'h78;
        tick();
        check("bne_ds_inst", id_inst, 32'h20840004);
        check("bne_ds_pc", pc, 32'h78);
        check("bne_ds_state", {30'b0, dbg_state}, 32'h1);
        pcsource = 2'b00;

        // Resume beats step
        resume_req = 1'b1; step_req = 1'b1;
        tick();
        check("resume_state", {30'b0, dbg_state}, 32'h0);
        check("resume_valid", {31'b0, id_valid}, 32'h0);
        resume_req = 1'b0; step_req = 1'b0;
        tick();
        check("run_inst", id_inst, 32'h00852022);
        check("run_pc", pc, 32'h7C);

        // jr out of the ROM window
        do_reset();
        for (int i = 0; i < 6; i++) tick();
        tick();
        check("jr_inst", id_inst, 32'h03e00008);
        pcsource = 2'b10; rpc = 32'h100;
        tick();
        check("jr_pc", pc, 32'h100);
        check("jr_ds_valid", {31'b0, id_valid}, 32'h1);
        pcsource = 2'b00;
        tick();
        check("flt_fault", {31'b0, fault}, 32'h1);
        check("flt_state", {30'b0, dbg_state}, 32'h3);
        check("flt_pc", pc, 32'h100);
        check("flt_valid", {31'b0, id_valid}, 32'h0);
        check("flt_pc4", id_pc4, 32'h104);
        resume_req = 1'b1;
        tick();
        resume_req = 1'b0;
        check("flt_resume_state", {30'b0, dbg_state}, 32'h3);
        check("flt_resume_valid", {31'b0, id_valid}, 32'h0);
        do_reset();
        check("flt_clr_fault", {31'b0, fault}, 32'h0);
        check("flt_clr_state", {30'b0, dbg_state}, 32'h0);

        // Async reset while in STEP
        halt_req = 1'b1;
        tick();
        check("d_halt_state", {30'b0, dbg_state}, 32'h1);
        halt_req = 1'b0; step_req = 1'b1;
        tick();
        step_req = 1'b0;
        check("d_step_state", {30'b0, dbg_state}, 32'h2);
        #3;
        rst = 1'b1;
        #1;
        check("arst_pc", pc, 32'h0);
        check("arst_state", {30'b0, dbg_state}, 32'h0);
        check("arst_inst", id_inst, 32'h0);
        check("arst_pc4", id_pc4, 32'h0);
        check("arst_valid", {31'b0, id_valid}, 32'h0);
        rst = 1'b0;
        tick();
        check("arst_fetch", id_inst, 32'h3c010000);

        // Misaligned target faults
        pcsource = 2'b11; jpc = 32'h6A;
        tick();
        check("mis_pc", pc, 32'h6A);
        pcsource = 2'b00;
        tick();
        check("mis_state", {30'b0, dbg_state}, 32'h3);
        check("mis_pc_hold", pc, 32'h6A);

        // Last legal word fetches, next one faults
        do_reset();
        pcsource = 2'b11; jpc = 32'hFC;
        tick();
        pcsource = 2'b00;
        tick();
        check("top_state", {30'b0, dbg_state}, 32'h0);
        check("top_valid", {31'b0, id_valid}, 32'h1);
        check("top_pc", pc, 32'h100);
        tick();
        check("top_fault", {31'b0, fault}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
